// File: rtl/uart_rx_ctrl_p_if.sv
// Receive-path bundle for uart_rx_ctrl_p: serial line and frame config in, received word and status out.
interface uart_rx_ctrl_p_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PRE_W  = 6
);
    logic              RX_IN;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              STOP2;
    logic [PRE_W-1:0]  prescale;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;
    logic              busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, STOP2, prescale,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, STOP2, prescale,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl_p.sv
// UART receive controller: 3-sample majority oversampling, optional parity, one or two stop bits.
module uart_rx_ctrl_p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PRE_W  = 6
) (
    input logic              CLK,
    input logic              RST,
    uart_rx_ctrl_p_if.slave  bus
);
    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d, edge_q, edge_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              s0_q, s0_d, s1_q, s1_d;
    logic [DATA_W-1:0] sh_q, sh_d, pdata_q, pdata_d;
    logic              par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic              perr_q, perr_d, serr_q, serr_d;
    logic              dv_q, dv_d, pe_q, pe_d, se_q, se_d;

    logic [PRE_W-1:0]  pre_even, pre_lat, half, samp_lo, samp_hi, last_edge;
    logic [BIT_W-1:0]  last_bit;
    logic              maj, wrap;

    assign pre_even  = bus.prescale & ~PRE_W'(1);
    assign pre_lat   = (pre_even < PRE_W'(4)) ? PRE_W'(4) : pre_even;
    assign half      = pre_q >> 1;
    assign samp_lo   = half - PRE_W'(1);
    assign samp_hi   = half + PRE_W'(1);
    assign last_edge = pre_q - PRE_W'(1);
    assign wrap      = (edge_q == last_edge);
    // Third vote is the live line value, so the bit decision lands on edge P/2+1.
    assign maj       = (s0_q & s1_q) | (s0_q & bus.RX_IN) | (s1_q & bus.RX_IN);
    assign last_bit  = BIT_W'(DATA_W + 1) + BIT_W'(par_en_q) + BIT_W'(stop2_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            edge_q    <= '0;
            bit_q     <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            sh_q      <= '0;
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            sh_q      <= sh_d;
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        edge_d    = wrap ? '0 : edge_q + PRE_W'(1);
        bit_d     = bit_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        sh_d      = sh_q;
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        perr_d    = perr_q;
        serr_d    = serr_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        if (edge_q == samp_lo) s0_d = bus.RX_IN;
        if (edge_q == half)    s1_d = bus.RX_IN;

        unique case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!bus.RX_IN) begin
                    state_d   = START;
                    edge_d    = PRE_W'(1);
                    pre_d     = pre_lat;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    stop2_d   = bus.STOP2;
                    perr_d    = 1'b0;
                    serr_d    = 1'b0;
                end
            end
            START: begin
                if (edge_q == samp_hi && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (wrap) begin
                    state_d = DATA;
                    bit_d   = bit_q + BIT_W'(1);
                end
            end
            DATA: begin
                // Shifting in at the MSB leaves the first (LSB) bit at position 0 after DATA_W bits.
                if (edge_q == samp_hi) sh_d = {maj, sh_q[DATA_W-1:1]};
                if (wrap) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_q == samp_hi && (maj != ((^sh_q) ^ par_typ_q))) perr_d = 1'b1;
                if (wrap) begin
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_q == samp_hi && !maj) serr_d = 1'b1;
                if (wrap) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == last_bit) begin
                        state_d = DONE;
                        if (!perr_q && !serr_d) begin
                            pdata_d = sh_q;
                            dv_d    = 1'b1;
                        end else begin
                            pe_d = perr_q;
                            se_d = serr_d;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.P_DATA     = pdata_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl_p.sv
// Directed bench for uart_rx_ctrl_p: frames are scored against a queue of expected results.
module tb_uart_rx_ctrl_p;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_p_if #(.DATA_W(8), .PRE_W(6)) bus8 ();
    uart_rx_ctrl_p_if #(.DATA_W(5), .PRE_W(6)) bus5 ();

    uart_rx_ctrl_p #(.DATA_W(8), .PRE_W(6)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_rx_ctrl_p #(.DATA_W(5), .PRE_W(6)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    typedef struct {
        logic [2:0] kind;   // {stp_err, par_err, data_valid}
        logic [8:0] data;
        int         cyc;
    } exp_t;

    exp_t       q8[$];
    exp_t       q5[$];
    logic [8:0] good8, good5;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic mon(input int sel, input logic [2:0] k, input logic [8:0] d);
        exp_t e;
        if (k === 3'b000) return;
        if ((sel == 0 && q8.size() == 0) || (sel == 1 && q5.size() == 0)) begin
            chk(sel == 0 ? "unexpected_out8" : "unexpected_out5", {29'd0, k}, 32'd0);
            return;
        end
        if (sel == 0) e = q8.pop_front();
        else          e = q5.pop_front();
        chk(sel == 0 ? "kind8" : "kind5", {29'd0, k}, {29'd0, e.kind});
        chk(sel == 0 ? "data8" : "data5", {23'd0, d}, {23'd0, e.data});
        chk(sel == 0 ? "cycle8" : "cycle5", cyc, e.cyc);
    endtask

    always @(negedge CLK) begin
        mon(0, {bus8.stp_err, bus8.par_err, bus8.data_valid}, {1'b0, bus8.P_DATA});
        mon(1, {bus5.stp_err, bus5.par_err, bus5.data_valid}, {4'd0, bus5.P_DATA});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) bus8.RX_IN = v;
        else          bus5.RX_IN = v;
    endtask

    task automatic drive_bit(input int sel, input logic v, input int p, input bit noise);
        for (int k = 0; k < p; k++) begin
            set_rx(sel, (noise && k == p / 2) ? ~v : v);
            tick();
        end
    endtask

    task automatic idle(input int n);
        bus8.RX_IN = 1'b1;
        bus5.RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    // Called in the cycle whose following edge is the start detection (cycle 0).
    task automatic send_frame(input int sel, input logic [8:0] data, input int nb, input bit pen,
                              input bit ptyp, input bit st2, input bit flip, input logic [1:0] stops,
                              input int p, input bit noise, input bit expect_out);
        exp_t e;
        int   n;
        logic par;
        n        = 2 + nb + int'(pen) + int'(st2);
        par      = (^data) ^ ptyp ^ flip;
        e.kind   = {~(stops[0] & (stops[1] | ~st2)), pen & flip, 1'b0};
        if (e.kind == 3'b000) begin
            e.kind = 3'b001;
            e.data = data;
        end else begin
            e.data = (sel == 0) ? good8 : good5;
        end
        e.cyc = cyc + n * p;
        if (expect_out) begin
            if (sel == 0) q8.push_back(e);
            else          q5.push_back(e);
            if (e.kind == 3'b001) begin
                if (sel == 0) good8 = data;
                else          good5 = data;
            end
        end
        drive_bit(sel, 1'b0, p, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(sel, data[i], p, noise);
        if (pen) drive_bit(sel, par, p, 1'b0);
        drive_bit(sel, stops[0], p, 1'b0);
        if (st2) drive_bit(sel, stops[1], p, 1'b0);
        set_rx(sel, 1'b1);
    endtask

    initial begin
        bus8.RX_IN = 1'b1; bus8.PAR_EN = 1'b0; bus8.PAR_TYP = 1'b0; bus8.STOP2 = 1'b0; bus8.prescale = 6'd8;
        bus5.RX_IN = 1'b1; bus5.PAR_EN = 1'b0; bus5.PAR_TYP = 1'b0; bus5.STOP2 = 1'b0; bus5.prescale = 6'd8;
        good8 = '0;
        good5 = '0;
        #1 RST = 1'b0;
        repeat (3) tick();
        chk("rst_pdata", {24'd0, bus8.P_DATA}, 32'd0);
        chk("rst_flags", {29'd0, bus8.data_valid, bus8.par_err, bus8.stp_err}, 32'd0);
        chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
        RST = 1'b1;
        idle(3);

        // 8N1, P=8
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b1);
        idle(2);

        // 8E1, P=16: good parity then flipped parity
        bus8.PAR_EN = 1'b1; bus8.PAR_TYP = 1'b0; bus8.prescale = 6'd16;
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16, 1'b0, 1'b1);
        idle(2);
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 16, 1'b0, 1'b1);
        idle(2);

        // 8O2, P=8, second stop bit low
        bus8.PAR_TYP = 1'b1; bus8.STOP2 = 1'b1; bus8.prescale = 6'd8;
        send_frame(0, 9'h0FF, 8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 8, 1'b0, 1'b1);
        idle(2);

        // Two-cycle glitch: busy only in cycles 1..5
        bus8.PAR_EN = 1'b0; bus8.PAR_TYP = 1'b0; bus8.STOP2 = 1'b0;
        set_rx(0, 1'b0);
        chk("glitch_busy_c0", {31'd0, bus8.busy}, 32'd0);
        tick();
        chk("glitch_busy_c1", {31'd0, bus8.busy}, 32'd1);
        tick();
        set_rx(0, 1'b1);
        repeat (3) tick();
        chk("glitch_busy_c5", {31'd0, bus8.busy}, 32'd1);
        tick();
        chk("glitch_busy_c6", {31'd0, bus8.busy}, 32'd0);
        idle(2);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b1);
        idle(2);

        // Noise at the centre sample of every data bit, P=16
        bus8.prescale = 6'd16;
        send_frame(0, 9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16, 1'b1, 1'b1);
        idle(2);

        // Reset mid-frame: asserted in cycle 40, released in cycle 45
        bus8.prescale = 6'd8;
        fork
            send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b0);
            begin
                repeat (39) tick();
                chk("pre_rst_busy", {31'd0, bus8.busy}, 32'd1);
                tick();
                RST = 1'b0;
                #1;
                chk("midrst_pdata", {24'd0, bus8.P_DATA}, 32'd0);
                chk("midrst_busy", {31'd0, bus8.busy}, 32'd0);
                chk("midrst_flags", {29'd0, bus8.data_valid, bus8.par_err, bus8.stp_err}, 32'd0);
                good8 = '0;
                repeat (5) tick();
                RST = 1'b1;
            end
        join
        idle(4);

        // Prescale input changed mid-frame is ignored
        fork
            send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b1);
            begin
                repeat (20) tick();
                bus8.prescale = 6'd16;
            end
        join
        bus8.prescale = 6'd8;
        idle(2);

        // DATA_W=5 instance
        send_frame(1, 9'h015, 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b1);
        idle(2);

        // Break, line held low: next frame detected at cycle N*P+1
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8, 1'b0, 1'b1);
        set_rx(0, 1'b0);
        tick();
        send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8, 1'b0, 1'b1);

        // Back-to-back with one bit of idle, smallest prescale (odd value rounds to 4)
        bus8.prescale = 6'd5;
        idle(4);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 1'b0, 1'b1);
        idle(4);
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4, 1'b0, 1'b1);
        idle(2);

        for (int i = 0; i < 300 && (q8.size() + q5.size()) != 0; i++) tick();
        chk("q8_drained", q8.size(), 32'd0);
        chk("q5_drained", q5.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl_p.md
# uart_rx_ctrl_p

Parametrised UART receive controller for the UART_RX path: detects the start edge, oversamples each bit with 3-sample majority voting, deserialises DATA_W data bits, checks optional even/odd parity and one or two stop bits, and presents the received word with a one-cycle valid strobe. It sits between the RX_IN pin (already synchronised into CLK) and the RX data/ALU-command path. Edge/bit counters, sampler and deserialiser are internal, so no external counter blocks are needed.

## Interface
- DATA_W, 8, data bits per frame (5..9), LSB first
- PRE_W, 6, width of prescale input (max oversampling 2^PRE_W-2)
- CLK  in  1  oversampling clock (prescale x baud)
- RST  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial input, idle high, synchronous to CLK
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd parity
- STOP2  in  1  1 = two stop bits
- prescale  in  PRE_W  oversampling ratio; LSB ignored, values <4 treated as 4
- P_DATA  out  DATA_W  last good word; held until next data_valid
- data_valid  out  1  one-cycle pulse, P_DATA updated same cycle
- par_err  out  1  one-cycle pulse, parity mismatch on completed frame
- stp_err  out  1  one-cycle pulse, any stop bit sampled 0
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- PAR_EN, PAR_TYP, STOP2, prescale (rounded even, clamped) latched on start detection; changes mid-frame ignored until next frame.
- IDLE: RX_IN==0 at a CLK edge -> START; that cycle is edge 0 of the start bit.
- edge_cnt runs 0..P-1 per bit (P = latched prescale), bit_cnt increments when edge_cnt wraps.
- Samples taken at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of 3.
- START: if majority is 1 (glitch) -> IDLE at edge P/2+2, no flags raised. Else at edge P-1 -> DATA.
- DATA: majority bit shifted into bit position bit_cnt-1 (LSB first); after DATA_W bits -> PARITY if PAR_EN else STOP.
- PARITY: expected = XOR(data) for even, ~XOR(data) for odd; mismatch recorded internally.
- STOP: one or two bits (STOP2); any majority-0 stop bit recorded as stop error. After last stop bit edge P-1 -> DONE.
- DONE (one cycle): if no errors, P_DATA <= shift reg, data_valid=1; else P_DATA unchanged, data_valid=0, par_err/stp_err pulsed per recorded error (both may pulse together). Then -> IDLE.
- Break (all zeros incl. stop): stp_err pulse, then IDLE; if RX_IN still low, IDLE immediately starts a new frame.

## Timing
- Frame length N = 1 + DATA_W + PAR_EN + 1 + STOP2 bits.
- Start-detect cycle = cycle 0; DONE (data_valid / error pulses) at cycle N*P exactly.
- Earliest next start detection: cycle N*P+1 (one IDLE cycle after DONE). Back-to-back frames with a line idle of one bit at P>=4 are always received.
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, busy=0, state IDLE, counters 0.
- Reset asserted mid-frame: all outputs and counters go to reset values immediately; no partial word or error flag is ever emitted.
- busy rises the cycle after start detection, falls the cycle after DONE.
- data_valid, par_err, stp_err never high for more than one cycle; data_valid never coincides with either error flag.

## Test plan
- 8N1, prescale=8, byte 0xA5 -> data_valid high exactly at cycle 80, P_DATA=0xA5, no error flags.
- 8E1, prescale=16, 0x3C with correct parity 0 then 0x3C with parity 1 -> first: data_valid, P_DATA=0x3C at cycle 176; second: par_err pulse, P_DATA stays 0x3C.
- 8O2, prescale=8, 0xFF with second stop bit driven 0 -> stp_err pulse at cycle 96, no data_valid.
- Glitch: RX_IN low for 2 cycles at prescale=8 -> returns to IDLE at cycle 6, no flags; following valid frame 0x5A received correctly.
- Single-cycle noise inside each data bit at sample point P/2 (prescale=16, 0x96) -> majority rejects noise, P_DATA=0x96; DATA_W=5 build with 0x15 -> data_valid at cycle 56 (prescale 8).
- Reset asserted at cycle 40 of an 8N1 frame, released at 45 -> all outputs 0, no flags; prescale changed mid-frame from 8 to 16 has no effect on that frame.
